// File: rtl/alu.sv
// 32-bit ALU (ADD/AND/XOR/OR, one-hot select) with ARM-style NZCV flags.
// Latency: one cycle; result and flags are registered on the rising edge of CLK.
// No backpressure: accepts a new operation every cycle; invalid selects hold the outputs.
module alu #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] OP_X,
    input  logic [WIDTH-1:0] OP_Y,
    input  logic [3:0]       ALU_CTRL,
    output logic [WIDTH-1:0] ALU_OUT,
    output logic [3:0]       NZCV
);

    localparam logic [3:0] CTRL_ADD = 4'b1000;
    localparam logic [3:0] CTRL_AND = 4'b0100;
    localparam logic [3:0] CTRL_XOR = 4'b0010;
    localparam logic [3:0] CTRL_OR  = 4'b0001;

    logic [WIDTH:0]   sum_ext;
    logic [WIDTH-1:0] res_nxt;
    logic             c_nxt;
    logic             v_nxt;
    logic             op_vld;

    // One adder result serves both signed and unsigned views; only C and V differ.
    assign sum_ext = {1'b0, OP_X} + {1'b0, OP_Y};

    always_comb begin
        res_nxt = '0;
        c_nxt   = 1'b0;
        v_nxt   = 1'b0;
        op_vld  = 1'b1;
        case (ALU_CTRL)
            CTRL_ADD: begin
                res_nxt = sum_ext[WIDTH-1:0];
                c_nxt   = sum_ext[WIDTH];
                v_nxt   = (OP_X[WIDTH-1] == OP_Y[WIDTH-1]) &&
                          (sum_ext[WIDTH-1] != OP_X[WIDTH-1]);
            end
            CTRL_AND: res_nxt = OP_X & OP_Y;
            CTRL_XOR: res_nxt = OP_X ^ OP_Y;
            CTRL_OR:  res_nxt = OP_X | OP_Y;
            default:  op_vld  = 1'b0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ALU_OUT <= '0;
            NZCV    <= 4'b0000;
        end else if (op_vld) begin
            ALU_OUT <= res_nxt;
            NZCV    <= {res_nxt[WIDTH-1], (res_nxt == '0), c_nxt, v_nxt};
        end
    end

endmodule

// File: tb/tb_alu.sv
// Directed bench for alu: hand-computed vectors checked one cycle after issue.
module tb_alu;

    logic        CLK;
    logic        RST;
    logic [31:0] OP_X;
    logic [31:0] OP_Y;
    logic [3:0]  ALU_CTRL;
    logic [31:0] ALU_OUT;
    logic [3:0]  NZCV;

    int checks   = 0;
    int failures = 0;

    alu #(.WIDTH(32)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .OP_X     (OP_X),
        .OP_Y     (OP_Y),
        .ALU_CTRL (ALU_CTRL),
        .ALU_OUT  (ALU_OUT),
        .NZCV     (NZCV)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Drive away from the active edge, clock it in, then sample 1 time unit later.
    task automatic step(input logic rst, input logic [31:0] x, input logic [31:0] y,
                        input logic [3:0] ctrl);
        @(negedge CLK);
        RST      = rst;
        OP_X     = x;
        OP_Y     = y;
        ALU_CTRL = ctrl;
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] exp_out, input logic [3:0] exp_f);
        checks++;
        assert (ALU_OUT === exp_out && NZCV === exp_f)
        else begin
            failures++;
            $error("FAIL %s: got out=%h nzcv=%b, expected out=%h nzcv=%b",
                   tag, ALU_OUT, NZCV, exp_out, exp_f);
        end
    endtask

    initial begin
        RST      = 1'b1;
        OP_X     = 32'hDEAD_BEEF;
        OP_Y     = 32'h1234_5678;
        ALU_CTRL = 4'b1000;

        // Reset held for two cycles with arbitrary inputs
        step(1'b1, 32'hDEAD_BEEF, 32'h1234_5678, 4'b1000);
        check("reset_cycle1", 32'h0000_0000, 4'b0000);
        step(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 4'b0001);
        check("reset_cycle2", 32'h0000_0000, 4'b0000);

        // Same operands through every operation
        step(1'b0, 32'hFF00_0000, 32'hF000_0000, 4'b1000);
        check("add_basic", 32'hEF00_0000, 4'b1010);
        step(1'b0, 32'hFF00_0000, 32'hF000_0000, 4'b0100);
        check("and_basic", 32'hF000_0000, 4'b1000);
        step(1'b0, 32'hFF00_0000, 32'hF000_0000, 4'b0010);
        check("xor_basic", 32'h0F00_0000, 4'b0000);
        step(1'b0, 32'hFF00_0000, 32'hF000_0000, 4'b0001);
        check("or_basic", 32'hFF00_0000, 4'b1000);

        // ADD boundaries
        step(1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 4'b1000);
        check("add_pos_overflow", 32'h8000_0000, 4'b1001);
        step(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 4'b1000);
        check("add_carry_zero", 32'h0000_0000, 4'b0110);
        step(1'b0, 32'h8000_0000, 32'h8000_0000, 4'b1000);
        check("add_neg_overflow", 32'h0000_0000, 4'b0111);
        step(1'b0, 32'h0000_0005, 32'h0000_0003, 4'b1000);
        check("add_small", 32'h0000_0008, 4'b0000);

        // Zero result from logical ops
        step(1'b0, 32'h1234_5678, 32'h1234_5678, 4'b0010);
        check("xor_zero", 32'h0000_0000, 4'b0100);
        step(1'b0, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 4'b0100);
        check("and_zero", 32'h0000_0000, 4'b0100);

        // Invalid selects hold the previous outputs
        step(1'b0, 32'hFF00_0000, 32'hF000_0000, 4'b0001);
        check("or_before_invalid", 32'hFF00_0000, 4'b1000);
        step(1'b0, 32'h0000_0001, 32'h0000_0001, 4'b0000);
        check("invalid_0000", 32'hFF00_0000, 4'b1000);
        step(1'b0, 32'h0000_0001, 32'h0000_0001, 4'b1100);
        check("invalid_1100", 32'hFF00_0000, 4'b1000);
        step(1'b0, 32'h0000_0000, 32'h0000_0000, 4'b1111);
        check("invalid_1111", 32'hFF00_0000, 4'b1000);

        // Reset coinciding with an ADD discards it; next cycle computes normally
        step(1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 4'b1000);
        check("reset_midstream", 32'h0000_0000, 4'b0000);
        step(1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 4'b1000);
        check("after_reset_add", 32'h8000_0000, 4'b1001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Safety net so the run always ends on its own
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, got none, expected finish");
        $fatal(1, "timeout");
    end

endmodule
